// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem_responder
// Purpose  : Single-outstanding data-memory target with configurable latency
//            for exercising the Memory stage against a stalling memory.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem_responder #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 11,
    parameter int LATENCY       = 2
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [XLEN-1:0]     i_req_addr,
    input  logic                i_req_wr_en,
    input  logic [XLEN-1:0]     i_req_wdata,
    input  logic [XLEN/8-1:0]   i_req_byte_sel,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_data,
    output logic                o_rsp_wr,
    output logic                o_rsp_err
);

    localparam int         c_WORDS  = 2 ** (DMEM_ADDR_BIT - 1);
    localparam logic [2:0] c_LAT_M1 = 3'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [2:0]      r_count;
    logic [XLEN-1:0] r_mem [c_WORDS];

    logic                     w_accept;
    logic                     w_err;
    logic [DMEM_ADDR_BIT-2:0] w_index;
    logic                     w_unused_addr;

    assign o_req_ready   = (r_state == c_IDLE) & i_rstn;
    assign o_rsp_valid   = (r_state == c_RESP);
    assign w_accept      = i_req_valid & o_req_ready;
    assign w_index       = i_req_addr[DMEM_ADDR_BIT:2];
    assign w_err         = |i_req_addr[XLEN-1:DMEM_ADDR_BIT+1];
    // Byte offset within the word is meaningless to a word-wide memory.
    assign w_unused_addr = &{1'b0, i_req_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= c_IDLE;
            r_count    <= 3'd0;
            o_rsp_data <= '0;
            o_rsp_wr   <= 1'b0;
            o_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_req_valid) begin
                        o_rsp_wr   <= i_req_wr_en;
                        o_rsp_err  <= w_err;
                        o_rsp_data <= (i_req_wr_en | w_err) ? '0 : r_mem[w_index];
                        r_count    <= c_LAT_M1;
                        r_state    <= (LATENCY == 1) ? c_RESP : c_WAIT;
                    end
                end
                c_WAIT: begin
                    r_count <= r_count - 3'd1;
                    if (r_count == 3'd1) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Stores commit at the accept edge; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_wr_en && !w_err) begin
            for (int k = 0; k < XLEN / 8; k++) begin
                if (i_req_byte_sel[k]) begin
                    r_mem[w_index][8*k +: 8] <= i_req_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dmem_responder
// Purpose  : Directed and randomized checks of riscv_dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dmem_responder;

    logic        clk;
    logic [2:0]  rstn;
    logic [2:0]  reqValid;
    logic [2:0]  reqReady;
    logic [2:0]  rspValid;
    logic [2:0]  rspReady;
    logic [2:0]  rspWr;
    logic [2:0]  rspErr;
    logic [31:0] rspData [3];
    logic [31:0] reqAddr;
    logic        reqWrEn;
    logic [31:0] reqWdata;
    logic [3:0]  reqByteSel;

    int nAsserts = 0;
    int nFails   = 0;

    // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 7.
    riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(11), .LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rstn(rstn[0]), .i_req_valid(reqValid[0]), .o_req_ready(reqReady[0]),
        .i_req_addr(reqAddr), .i_req_wr_en(reqWrEn), .i_req_wdata(reqWdata),
        .i_req_byte_sel(reqByteSel), .o_rsp_valid(rspValid[0]), .i_rsp_ready(rspReady[0]),
        .o_rsp_data(rspData[0]), .o_rsp_wr(rspWr[0]), .o_rsp_err(rspErr[0]));
    riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(11), .LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn[1]), .i_req_valid(reqValid[1]), .o_req_ready(reqReady[1]),
        .i_req_addr(reqAddr), .i_req_wr_en(reqWrEn), .i_req_wdata(reqWdata),
        .i_req_byte_sel(reqByteSel), .o_rsp_valid(rspValid[1]), .i_rsp_ready(rspReady[1]),
        .o_rsp_data(rspData[1]), .o_rsp_wr(rspWr[1]), .o_rsp_err(rspErr[1]));
    riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(11), .LATENCY(7)) u_dut7 (
        .i_clk(clk), .i_rstn(rstn[2]), .i_req_valid(reqValid[2]), .o_req_ready(reqReady[2]),
        .i_req_addr(reqAddr), .i_req_wr_en(reqWrEn), .i_req_wdata(reqWdata),
        .i_req_byte_sel(reqByteSel), .o_rsp_valid(rspValid[2]), .i_rsp_ready(rspReady[2]),
        .o_rsp_data(rspData[2]), .o_rsp_wr(rspWr[2]), .o_rsp_err(rspErr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d with i_rsp_ready held high.
    task automatic xact(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] bsel,
                        output logic [31:0] data, output logic rwr, output logic rerr,
                        output int lat);
        @(negedge clk);
        check("req_ready_idle", 32'(reqReady[d]), 32'd1);
        reqValid[d] = 1'b1;
        reqWrEn     = wr;
        reqAddr     = addr;
        reqWdata    = wdata;
        reqByteSel  = bsel;
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
        reqAddr     = $urandom;
        reqWdata    = $urandom;
        reqWrEn     = 1'($urandom);
        reqByteSel  = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspValid[d] && lat < 20);
        if (lat >= 20) check("rsp_timeout", 32'(rspValid[d]), 32'd1);
        data = rspData[d];
        rwr  = rspWr[d];
        rerr = rspErr[d];
        @(posedge clk);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] bsel);
        logic [31:0] mask = 32'd0;
        for (int k = 0; k < 4; k++) if (bsel[k]) mask |= (32'hFF << (8 * k));
        return (old & ~mask) | (wd & mask);
    endfunction

    logic [31:0] mdl [16];
    logic [31:0] data;
    logic        rwr, rerr;
    int          lat;

    initial begin
        rstn = 3'b000; reqValid = 3'b000; rspReady = 3'b111;
        reqAddr = 0; reqWrEn = 0; reqWdata = 0; reqByteSel = 0;

        // Reset behaviour
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req_ready", 32'(reqReady), 32'd0);
            check("rst_rsp_valid", 32'(rspValid), 32'd0);
        end
        rstn = 3'b111;
        @(negedge clk);
        check("post_rst_ready", 32'(reqReady), 32'h7);
        check("post_rst_valid", 32'(rspValid), 32'd0);
        check("post_rst_data", rspData[0], 32'd0);
        check("post_rst_wr", 32'(rspWr), 32'd0);
        check("post_rst_err", 32'(rspErr), 32'd0);

        // Full store then load
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, data, rwr, rerr, lat);
        check("st_lat", lat, 2); check("st_wr", 32'(rwr), 1);
        check("st_err", 32'(rerr), 0); check("st_data", data, 0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, data, rwr, rerr, lat);
        check("ld_lat", lat, 2); check("ld_data", data, 32'hDEADBEEF);
        check("ld_wr", 32'(rwr), 0);

        // Partial store
        xact(0, 1'b1, 32'h12, 32'h0000AA00, 4'b0010, data, rwr, rerr, lat);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, data, rwr, rerr, lat);
        check("partial_data", data, 32'hDEADAAEF);

        // Backpressure
        @(negedge clk);
        rspReady[0] = 1'b0; reqValid[0] = 1'b1; reqWrEn = 1'b0; reqAddr = 32'h10;
        @(posedge clk);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rspValid[0] && lat < 20);
        check("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", 32'(rspValid[0]), 1);
            check("bp_data", rspData[0], 32'hDEADAAEF);
            check("bp_ready", 32'(reqReady[0]), 0);
        end
        rspReady[0] = 1'b1;
        @(negedge clk);
        check("bp_ready_after_hs", 32'(reqReady[0]), 1);
        check("bp_valid_after_hs", 32'(rspValid[0]), 0);
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        check("bp_next_accepted", 32'(reqReady[0]), 0);
        lat = 1;
        while (!rspValid[0] && lat < 20) begin @(negedge clk); lat++; end
        check("bp_next_lat", lat, 2);
        check("bp_next_data", rspData[0], 32'hDEADAAEF);
        @(posedge clk);

        // Out of range store must not alias word 0
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, data, rwr, rerr, lat);
        xact(0, 1'b1, 32'h1000, 32'h12345678, 4'b1111, data, rwr, rerr, lat);
        check("oor_err", 32'(rerr), 1); check("oor_data", data, 0);
        xact(0, 1'b0, 32'h0, 32'h0, 4'b0000, data, rwr, rerr, lat);
        check("oor_word0", data, 32'hCAFEF00D); check("oor_ld_err", 32'(rerr), 0);

        // Randomized traffic against a word-array model
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            xact(0, 1'b1, 32'h100 + 32'(i) * 4, mdl[i], 4'b1111, data, rwr, rerr, lat);
        end
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, wd;
            logic [3:0]  bs;
            logic        w, e;
            int          idx;
            idx = $urandom_range(0, 15);
            a   = 32'h100 + 32'(idx) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = (32'd1 << $urandom_range(12, 31)) | 32'($urandom_range(0, 4095));
            w  = 1'($urandom);
            wd = $urandom;
            bs = 4'($urandom);
            e  = (a >= 32'h1000);
            xact(0, w, a, wd, bs, data, rwr, rerr, lat);
            check("rnd_lat", lat, 2);
            check("rnd_wr", 32'(rwr), 32'(w));
            check("rnd_err", 32'(rerr), 32'(e));
            check("rnd_data", data, (w || e) ? 32'd0 : mdl[idx]);
            if (w && !e) mdl[idx] = merge(mdl[idx], wd, bs);
        end

        // Latency sweep
        xact(1, 1'b1, 32'h40, 32'h11223344, 4'b1111, data, rwr, rerr, lat);
        check("lat1_st", lat, 1);
        xact(1, 1'b0, 32'h40, 32'h0, 4'b0000, data, rwr, rerr, lat);
        check("lat1_ld", lat, 1); check("lat1_data", data, 32'h11223344);
        xact(2, 1'b1, 32'h44, 32'h55667788, 4'b1111, data, rwr, rerr, lat);
        check("lat7_st", lat, 7);
        xact(2, 1'b0, 32'h44, 32'h0, 4'b0000, data, rwr, rerr, lat);
        check("lat7_ld", lat, 7); check("lat7_data", data, 32'h55667788);

        // Reset during WAIT drops the response
        @(negedge clk);
        reqValid[2] = 1'b1; reqWrEn = 1'b0; reqAddr = 32'h44;
        @(posedge clk);
        #1;
        reqValid[2] = 1'b0;
        repeat (3) @(negedge clk);
        rstn[2] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_ready", 32'(reqReady[2]), 0);
            check("midrst_valid", 32'(rspValid[2]), 0);
        end
        rstn[2] = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", 32'(reqReady[2]), 1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                seen |= rspValid[2];
            end
            check("midrst_no_rsp", 32'(seen), 0);
        end
        xact(2, 1'b0, 32'h44, 32'h0, 4'b0000, data, rwr, rerr, lat);
        check("midrst_mem_kept", data, 32'h55667788);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
`default_nettype wire
